// File: rtl/ipsxe_floating_point_apm_share_arb_v1_0.sv
// Shares one pipelined APM post-add slice between NUM_REQ requesters: grant, register operands, track tags, return results.
// Optional IPSXE_FLOATING_POINT_APM_ARB_RR_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module ipsxe_floating_point_apm_share_arb_v1_0 #(
  parameter int NUM_REQ     = 4,
  parameter int X_WIDTH     = 4,
  parameter int Z_WIDTH     = 10,
  parameter int P_WIDTH     = 10,
  parameter int APM_LATENCY = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*X_WIDTH-1:0]   i_req_x,
  input  logic [NUM_REQ*Z_WIDTH-1:0]   i_req_z,
  output logic [X_WIDTH-1:0]           o_apm_x,
  output logic [Z_WIDTH-1:0]           o_apm_z,
  input  logic [P_WIDTH-1:0]           i_apm_p,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [P_WIDTH-1:0]           o_rsp_data,
  output logic                         o_busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = APM_LATENCY + 1;

  logic [NUM_REQ-1:0]            gnt;
  logic [IDX_W-1:0]              gnt_idx;
  logic                          hs;
  int                            j;

  logic [X_WIDTH-1:0]            apm_x_q, apm_x_d;
  logic [Z_WIDTH-1:0]            apm_z_q, apm_z_d;
  logic [STAGES-1:0]             vld_pipe_q, vld_pipe_d;
  logic [STAGES-1:0][IDX_W-1:0]  idx_pipe_q, idx_pipe_d;
  logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [P_WIDTH-1:0]            rsp_data_q, rsp_data_d;

`ifdef IPSXE_FLOATING_POINT_APM_ARB_RR_EN
  logic [IDX_W-1:0]              ptr_q, ptr_d;
`endif

  // Grant scans from the priority start point; only valid requesters can win, so grant implies handshake.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hs      = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef IPSXE_FLOATING_POINT_APM_ARB_RR_EN
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`else
      j = k;
`endif
      if (!hs && i_req_valid[j]) begin
        hs      = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    if (i_rst) begin
      gnt = '0;
      hs  = 1'b0;
    end
  end

  always_comb begin
    apm_x_d     = apm_x_q;
    apm_z_d     = apm_z_q;
    vld_pipe_d  = '0;
    idx_pipe_d  = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    if (hs) begin
      apm_x_d = i_req_x[int'(gnt_idx)*X_WIDTH +: X_WIDTH];
      apm_z_d = i_req_z[int'(gnt_idx)*Z_WIDTH +: Z_WIDTH];
    end

    // Tag shift runs every cycle so latency stays fixed regardless of contention.
    vld_pipe_d[0] = hs;
    idx_pipe_d[0] = gnt_idx;
    for (int s = 1; s < STAGES; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      idx_pipe_d[s] = idx_pipe_q[s-1];
    end

    if (vld_pipe_q[STAGES-1]) begin
      rsp_data_d = i_apm_p;
      for (int k = 0; k < NUM_REQ; k++)
        rsp_valid_d[k] = (idx_pipe_q[STAGES-1] == IDX_W'(k));
    end
  end

`ifdef IPSXE_FLOATING_POINT_APM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      apm_x_q     <= '0;
      apm_z_q     <= '0;
      vld_pipe_q  <= '0;
      idx_pipe_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      apm_x_q     <= apm_x_d;
      apm_z_q     <= apm_z_d;
      vld_pipe_q  <= vld_pipe_d;
      idx_pipe_q  <= idx_pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_req_ready = gnt;
  assign o_apm_x     = apm_x_q;
  assign o_apm_z     = apm_z_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = |vld_pipe_q;

endmodule

// File: tb/tb_ipsxe_floating_point_apm_share_arb_v1_0.sv
// Scoreboard bench: four arbiters (APM latency 0..3) share one stimulus stream; a monitor per instance checks strobes.
module tb_ipsxe_floating_point_apm_share_arb_v1_0;

  localparam int NR = 4;
  localparam int NI = 4;

  typedef struct {
    int         idx;
    logic [9:0] data;
    int         cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        req_valid = '0;
  logic [NR*4-1:0]      req_x = '0;
  logic [NR*10-1:0]     req_z = '0;

  logic [NI-1:0][NR-1:0] rdy_a, rspv_a;
  logic [NI-1:0][3:0]    ax_a;
  logic [NI-1:0][9:0]    az_a, ap_a, rd_a;
  logic [NI-1:0]         busy_a;

  exp_t       sb [NI][$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         mptr = 0;
  logic [3:0] last_x = '0;
  logic [9:0] last_z = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s lat%0d cyc%0d: got %0h expected %0h", name, inst, cyc, got, want);
    end
  endtask

  function automatic logic [9:0] apm_ref(input logic [3:0] x, input logic [9:0] z);
    int sx;
    sx = (x >= 8) ? int'(x) - 16 : int'(x);
    return 10'((sx + int'(z)) & 1023);
  endfunction

  // Reference arbitration straight from the rules: first valid index starting at the pointer.
  function automatic int model_grant(input logic [NR-1:0] v);
    int jj;
    for (int k = 0; k < NR; k++) begin
`ifdef IPSXE_FLOATING_POINT_APM_ARB_RR_EN
      jj = (mptr + k) % NR;
`else
      jj = k;
`endif
      if (v[jj]) return jj;
    end
    return -1;
  endfunction

  for (genvar L = 0; L < NI; L++) begin : g_lat
    logic [9:0] p_now;
    logic [9:0] pdly [0:3];

    ipsxe_floating_point_apm_share_arb_v1_0 #(
      .NUM_REQ(NR), .X_WIDTH(4), .Z_WIDTH(10), .P_WIDTH(10), .APM_LATENCY(L)
    ) u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(rdy_a[L]),
      .i_req_x(req_x), .i_req_z(req_z),
      .o_apm_x(ax_a[L]), .o_apm_z(az_a[L]), .i_apm_p(ap_a[L]),
      .o_rsp_valid(rspv_a[L]), .o_rsp_data(rd_a[L]), .o_busy(busy_a[L])
    );

    assign p_now = apm_ref(ax_a[L], az_a[L]);
    always @(posedge clk) begin
      pdly[0] <= p_now;
      for (int i = 1; i < 4; i++) pdly[i] <= pdly[i-1];
    end
    if (L == 0) begin : g_comb
      assign ap_a[L] = p_now;
    end else begin : g_reg
      assign ap_a[L] = pdly[L-1];
    end

    always @(negedge clk) begin
      exp_t e;
      logic eb;
      if (sb[L].size() > 0 && sb[L][0].cyc == cyc) begin
        e = sb[L].pop_front();
        check("rsp_valid", L, 32'(rspv_a[L]), 32'(4'b0001 << e.idx));
        check("rsp_data", L, 32'(rd_a[L]), 32'(e.data));
      end else begin
        check("no_strobe", L, 32'(rspv_a[L]), 32'd0);
      end
      eb = 1'b0;
      foreach (sb[L][i])
        if (cyc < sb[L][i].cyc && cyc >= sb[L][i].cyc - L - 1) eb = 1'b1;
      check("busy", L, 32'(busy_a[L]), 32'(eb));
    end
  end

  // One cycle of stimulus: drive at the falling edge, check combinational grant and held operands, record expectations.
  task automatic step(input logic r, input logic [NR-1:0] v, input logic [NR*4-1:0] x, input logic [NR*10-1:0] z);
    int g;
    logic [NR-1:0] eg;
    @(negedge clk);
    #1;
    rst = r;
    if (r) begin
      for (int i = 0; i < NI; i++) sb[i].delete();
      mptr = 0;
      last_x = '0;
      last_z = '0;
    end
    req_valid = v;
    req_x = x;
    req_z = z;
    #1;
    g = r ? -1 : model_grant(v);
    eg = (g < 0) ? '0 : NR'(1 << g);
    for (int i = 0; i < NI; i++) begin
      check("req_ready", i, 32'(rdy_a[i]), 32'(eg));
      check("apm_x", i, 32'(ax_a[i]), 32'(last_x));
      check("apm_z", i, 32'(az_a[i]), 32'(last_z));
      if (r) begin
        check("rst_rsp_data", i, 32'(rd_a[i]), 32'd0);
        check("rst_rsp_valid", i, 32'(rspv_a[i]), 32'd0);
        check("rst_busy", i, 32'(busy_a[i]), 32'd0);
      end
    end
    if (g >= 0) begin
      last_x = x[g*4 +: 4];
      last_z = z[g*10 +: 10];
      for (int i = 0; i < NI; i++)
        sb[i].push_back('{idx: g, data: apm_ref(last_x, last_z), cyc: cyc + i + 2});
      mptr = (g + 1) % NR;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, req_x, req_z);
  endtask

  task automatic rand_ops(input logic [NR-1:0] v, output logic [NR*4-1:0] x, output logic [NR*10-1:0] z);
    x = NR*4'($urandom);
    for (int k = 0; k < NR; k++) z[k*10 +: 10] = 10'($urandom);
    if (v == '0) x = x;
  endtask

  initial begin
    logic [NR*4-1:0]  x;
    logic [NR*10-1:0] z;

    // Reset with every requester asking, then a single req1 operation right at release.
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 16'hFFFF, '1);
    x = '0; z = '0;
    x[4 +: 4] = 4'b1110;
    z[10 +: 10] = 10'd5;
    step(1'b0, 4'b0010, x, z);
    idle(6);

    // Full contention.
    for (int i = 0; i < 6; i++) begin
      rand_ops(4'hF, x, z);
      step(1'b0, 4'hF, x, z);
    end
    idle(6);

    // Pointer wrap: req2 alone moves the pointer to 3, then req0 and req2 compete.
    rand_ops(4'h4, x, z);
    step(1'b0, 4'b0100, x, z);
    for (int i = 0; i < 2; i++) begin
      rand_ops(4'h5, x, z);
      step(1'b0, 4'b0101, x, z);
    end
    idle(6);

    // Result that wraps modulo 2^10.
    x = '0; z = '0;
    x[8 +: 4] = 4'b0111;
    z[20 +: 10] = 10'h3FF;
    step(1'b0, 4'b0100, x, z);
    idle(6);

    // Reset one cycle after three back-to-back issues drops the in-flight results.
    for (int i = 0; i < 3; i++) begin
      rand_ops(4'hF, x, z);
      step(1'b0, 4'b1001, x, z);
    end
    step(1'b0, '0, x, z);
    step(1'b1, '0, x, z);
    step(1'b1, 4'hF, x, z);
    rand_ops(4'h8, x, z);
    step(1'b0, 4'b1000, x, z);
    idle(6);

    // Single op then a long idle stretch: operands must hold.
    rand_ops(4'h2, x, z);
    step(1'b0, 4'b0010, x, z);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      logic [NR-1:0] v;
      v = NR'($urandom_range(0, 15));
      rand_ops(v, x, z);
      step(1'b0, v, x, z);
    end
    idle(8);

    for (int i = 0; i < NI; i++) check("sb_drained", i, 32'(sb[i].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
